// File: rtl/systolic_tile_sequencer.sv
// Single-tile sequencer for the 4x4 output-stationary systolic array:
// clear, stream K operand vectors, wait for completion, drain 16 results row-major.
`timescale 1ns/1ps
module systolic_tile_sequencer #(
  parameter int INPUT_WIDTH   = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int VECTOR_LENGTH = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int TIMEOUT       = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     a_base,
  input  logic [ADDR_WIDTH-1:0]     b_base,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      a_rd_en,
  output logic [ADDR_WIDTH-1:0]     a_rd_addr,
  input  logic [INPUT_WIDTH*4-1:0]  a_rd_data,
  output logic                      b_rd_en,
  output logic [ADDR_WIDTH-1:0]     b_rd_addr,
  input  logic [INPUT_WIDTH*4-1:0]  b_rd_data,
  output logic                      arr_tile_clear,
  output logic                      arr_feed_valid,
  output logic [INPUT_WIDTH*4-1:0]  arr_row_data,
  output logic [INPUT_WIDTH*4-1:0]  arr_col_data,
  input  logic                      arr_ready_for_feed,
  input  logic                      arr_tile_done,
  input  logic [ACC_WIDTH*16-1:0]   arr_result_flat,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_WIDTH-1:0]      res_data,
  output logic [3:0]                res_index,
  output logic                      res_last
);
  localparam int KW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, DRAIN} state_t;

  state_t                      state;
  logic [ADDR_WIDTH-1:0]       a_base_q, b_base_q;
  logic [KW-1:0]               k;
  logic [WW-1:0]               wd;
  logic [15:0][ACC_WIDTH-1:0]  cap;
  logic [3:0]                  nxt;

  assign nxt = res_index + 4'd1;

  // Read data arrives one cycle after the strobe, aligned with feed_valid.
  assign arr_row_data = arr_feed_valid ? a_rd_data : '0;
  assign arr_col_data = arr_feed_valid ? b_rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      a_base_q       <= '0;
      b_base_q       <= '0;
      k              <= '0;
      wd             <= '0;
      cap            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      a_rd_en        <= 1'b0;
      b_rd_en        <= 1'b0;
      a_rd_addr      <= '0;
      b_rd_addr      <= '0;
      arr_tile_clear <= 1'b0;
      arr_feed_valid <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_index      <= '0;
      res_last       <= 1'b0;
    end else begin
      done           <= 1'b0;
      error          <= 1'b0;
      arr_tile_clear <= 1'b0;
      arr_feed_valid <= a_rd_en;
      case (state)
        IDLE: if (start && arr_ready_for_feed) begin
          a_base_q       <= a_base;
          b_base_q       <= b_base;
          busy           <= 1'b1;
          arr_tile_clear <= 1'b1;
          state          <= CLEAR;
        end
        CLEAR: begin
          k         <= '0;
          a_rd_en   <= 1'b1;
          b_rd_en   <= 1'b1;
          a_rd_addr <= a_base_q;
          b_rd_addr <= b_base_q;
          state     <= FEED;
        end
        FEED: if (k == KW'(VECTOR_LENGTH - 1)) begin
          a_rd_en <= 1'b0;
          b_rd_en <= 1'b0;
          wd      <= WW'(1);
          state   <= WAIT;
        end else begin
          k         <= k + KW'(1);
          a_rd_addr <= a_base_q + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
          b_rd_addr <= b_base_q + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
        end
        WAIT: if (arr_tile_done) begin
          // element 0 is taken straight from the array so it is valid next cycle
          cap       <= arr_result_flat;
          res_valid <= 1'b1;
          res_data  <= arr_result_flat[ACC_WIDTH-1:0];
          res_index <= 4'd0;
          res_last  <= 1'b0;
          state     <= DRAIN;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          done  <= 1'b1;
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          wd <= wd + WW'(1);
        end
        DRAIN: if (res_ready) begin
          if (res_index == 4'd15) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_index <= '0;
            res_last  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            res_index <= nxt;
            res_data  <= cap[nxt];
            res_last  <= (nxt == 4'd15);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: operand RAM + behavioural array stub,
// matrix-product reference, table-driven tiles plus random tiles and reset/timeout corners.
`timescale 1ns/1ps
module tb_systolic_tile_sequencer;
  localparam int IW = 8, AW = 16, K = 4, ADW = 8, TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, res_ready = 1'b1, arr_ready_for_feed = 1'b1;
  logic [ADW-1:0] a_base = '0, b_base = '0;
  logic busy, done, error, a_rd_en, b_rd_en, arr_tile_clear, arr_feed_valid;
  logic [ADW-1:0] a_rd_addr, b_rd_addr;
  logic [4*IW-1:0] a_rd_data, b_rd_data, arr_row_data, arr_col_data;
  logic arr_tile_done, res_valid, res_last;
  logic [AW*16-1:0] arr_result_flat;
  logic [AW-1:0] res_data;
  logic [3:0] res_index;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.INPUT_WIDTH(IW), .ACC_WIDTH(AW), .VECTOR_LENGTH(K),
                            .ADDR_WIDTH(ADW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a_base(a_base), .b_base(b_base),
    .busy(busy), .done(done), .error(error),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .arr_tile_clear(arr_tile_clear), .arr_feed_valid(arr_feed_valid),
    .arr_row_data(arr_row_data), .arr_col_data(arr_col_data),
    .arr_ready_for_feed(arr_ready_for_feed), .arr_tile_done(arr_tile_done),
    .arr_result_flat(arr_result_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_index(res_index), .res_last(res_last));

  // operand buffers: synchronous read, one-cycle latency
  logic [4*IW-1:0] a_mem [256];
  logic [4*IW-1:0] b_mem [256];
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  // array stub: accumulate outer products, pulse tile_done a few cycles after the K-th beat
  logic [AW-1:0] acc [4][4];
  int beats_in, cd;
  bit never_done = 1'b0;
  logic tdone;
  always @(posedge clk) begin
    tdone <= 1'b0;
    if (rst) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) acc[r][c] <= '0;
      beats_in <= 0;
      cd <= 0;
    end else begin
      if (arr_tile_clear) begin
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) acc[r][c] <= '0;
        beats_in <= 0;
      end else if (arr_feed_valid) begin
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
          acc[r][c] <= acc[r][c] + AW'(arr_row_data[r*IW +: IW]) * AW'(arr_col_data[c*IW +: IW]);
        beats_in <= beats_in + 1;
        if (beats_in + 1 == K && !never_done) cd <= 2;
      end
      if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) tdone <= 1'b1;
      end
    end
  end
  assign arr_tile_done = tdone;
  always_comb begin
    arr_result_flat = '0;
    for (int i = 0; i < 16; i++) arr_result_flat[i*AW +: AW] = acc[i/4][i%4];
  end

  // reference model: C = A x B (mod 2^AW), kept as plain matrices
  int am [4][K];
  int bm [K][4];
  logic [AW-1:0] cexp [16];

  task automatic build(input int kind, input logic [7:0] ab, input logic [7:0] bb);
    logic [4*IW-1:0] w;
    logic [AW-1:0] s;
    for (int r = 0; r < 4; r++) for (int k = 0; k < K; k++)
      am[r][k] = (kind == 0) ? int'(r == k) : (kind == 1) ? 2 : int'($urandom_range(0, 255));
    for (int k = 0; k < K; k++) for (int c = 0; c < 4; c++)
      bm[k][c] = (kind == 0) ? k*4 + c + 1 : (kind == 1) ? 2 : int'($urandom_range(0, 255));
    for (int k = 0; k < K; k++) begin
      w = '0;
      for (int i = 0; i < 4; i++) w[i*IW +: IW] = IW'(am[i][k]);
      a_mem[8'(ab + 8'(k))] = w;
      w = '0;
      for (int j = 0; j < 4; j++) w[j*IW +: IW] = IW'(bm[k][j]);
      b_mem[8'(bb + 8'(k))] = w;
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      s = '0;
      for (int k = 0; k < K; k++) s = s + AW'(am[r][k] * bm[k][c]);
      cexp[r*4 + c] = s;
    end
  endtask

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // recorder, sampled on the falling edge
  typedef struct { int idx; int data; bit last; int cyc; } beat_t;
  beat_t beats[$];
  int fv[$], ra[$], rb[$];
  int cyc = 0, n_clr, c_clr, c_td, c_done, n_done, n_rv, hold_mis, bus_mis, en_mis;
  bit done_err, done_busy, pstall;
  logic [AW+6:0] pval;

  task automatic clear_rec();
    beats.delete(); fv.delete(); ra.delete(); rb.delete();
    n_clr = 0; c_clr = 0; c_td = 0; c_done = 0; n_done = 0; n_rv = 0;
    hold_mis = 0; bus_mis = 0; en_mis = 0; done_err = 0; done_busy = 0; pstall = 0;
  endtask

  task automatic record();
    if (arr_tile_clear) begin n_clr++; c_clr = cyc; end
    if (arr_feed_valid) fv.push_back(cyc);
    if (!arr_feed_valid && (arr_row_data != 0 || arr_col_data != 0)) bus_mis++;
    if (a_rd_en != b_rd_en) en_mis++;
    if (a_rd_en) begin ra.push_back(int'(a_rd_addr)); rb.push_back(int'(b_rd_addr)); end
    if (arr_tile_done) c_td = cyc;
    if (res_valid) n_rv++;
    if (pstall && {res_valid, res_data, res_index, res_last} != pval) hold_mis++;
    pstall = res_valid && !res_ready;
    pval = {res_valid, res_data, res_index, res_last};
    if (res_valid && res_ready) beats.push_back('{int'(res_index), int'(res_data), res_last, cyc});
    if (done) begin n_done++; c_done = cyc; done_err = error; done_busy = busy; end
  endtask

  task automatic step();
    @(negedge clk);
    record();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic any_out();
    return |{busy, done, error, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_tile_clear,
             arr_feed_valid, arr_row_data, arr_col_data, res_valid, res_data, res_index, res_last};
  endfunction

  typedef struct {
    int kind; logic [7:0] ab; logic [7:0] bb; int stall_at; int stall_len;
    bit sfeed; bit sdrain; bit nodone; bit rnd;
    int exp_beats; bit exp_err; bit use_const; int exp0; int exp15;
  } vec_t;

  task automatic run_tile(input vec_t v);
    int n, scnt;
    bit p1, p2;
    clear_rec();
    never_done = v.nodone;
    build(v.kind, v.ab, v.bb);
    a_base = v.ab; b_base = v.bb; start = 1'b1;
    step();
    n = 0; scnt = 0; p1 = 0; p2 = 0;
    while (n_done == 0 && n < 300) begin
      start = 1'b0;
      if (v.sfeed && a_rd_en && !p1) begin start = 1'b1; p1 = 1; end
      else if (v.sdrain && res_valid && !p2) begin start = 1'b1; p2 = 1; end
      if (v.rnd) res_ready = 1'($urandom_range(0, 1));
      else if (res_valid && beats.size() == v.stall_at && scnt < v.stall_len) begin
        res_ready = 1'b0; scnt++;
      end else res_ready = 1'b1;
      step();
      n++;
    end
    start = 1'b0; res_ready = 1'b1;
    chk("done_count", n_done, 1);
    chk("done_error", done_err, v.exp_err);
    chk("done_busy", done_busy, 0);
    chk("clear_pulses", n_clr, 1);
    chk("feed_beats", fv.size(), K);
    if (fv.size() == K) begin
      chk("feed_first_cycle", fv[0], c_clr + 2);
      chk("feed_last_cycle", fv[K-1], c_clr + K + 1);
    end
    chk("read_count", ra.size(), K);
    for (int k = 0; k < K && k < ra.size(); k++) begin
      chk("a_rd_addr", ra[k], (int'(v.ab) + k) % 256);
      chk("b_rd_addr", rb[k], (int'(v.bb) + k) % 256);
    end
    chk("beat_count", beats.size(), v.exp_beats);
    if (v.exp_err) begin
      chk("timeout_cycle", c_done, c_clr + K + TO);
      chk("res_valid_cycles", n_rv, 0);
    end else begin
      foreach (beats[i]) begin
        chk("res_index", beats[i].idx, i);
        chk("res_data", beats[i].data, cexp[i % 16]);
        chk("res_last", beats[i].last, i == 15);
      end
      if (v.use_const && beats.size() == 16) begin
        chk("res_data_first", beats[0].data, v.exp0);
        chk("res_data_last", beats[15].data, v.exp15);
      end
      if (!v.rnd && beats.size() > 0) begin
        chk("res_valid_cycles", n_rv, 16 + v.stall_len);
        if (v.stall_len == 0) begin
          chk("first_beat_cycle", beats[0].cyc, c_td + 1);
          chk("done_cycle", c_done, c_td + 17);
        end
      end
    end
    chk("hold_stable", hold_mis, 0);
    chk("bus_zero_when_idle", bus_mis, 0);
    chk("b_en_eq_a_en", en_mis, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int found;

  initial begin
    //          kind ab     bb     st ln sf sd nd rn beats err const e0 e15
    tbl[0] = '{0, 8'h10, 8'h40, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1, 16};
    tbl[1] = '{1, 8'h20, 8'h60, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, 16};
    tbl[2] = '{0, 8'h05, 8'h85, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1, 16};
    tbl[3] = '{1, 8'd254, 8'd253, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, 16};
    tbl[4] = '{1, 8'h30, 8'h50, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{0, 8'h70, 8'h90, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1, 16};

    clear_rec();
    rst = 1'b1;
    step(); step();
    chk("reset_outputs", any_out(), 0);
    rst = 1'b0;
    step();

    // start is refused while the array is not ready
    clear_rec();
    arr_ready_for_feed = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start_not_ready_busy", busy, 0);
    chk("start_not_ready_clear", n_clr, 0);
    arr_ready_for_feed = 1'b1;

    for (int i = 0; i < 6; i++) run_tile(tbl[i]);

    // reset in the middle of FEED (k=2)
    clear_rec();
    build(0, 8'h30, 8'h70);
    a_base = 8'h30; b_base = 8'h70; start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      if (a_rd_en && a_rd_addr == 8'h32) found = 1;
      else step();
    end
    chk("reach_feed_k2", found, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_outputs", any_out(), 0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) step();
    chk("rst_mid_no_done", n_done, 0);
    chk("rst_mid_idle", busy, 0);
    run_tile(tbl[0]);

    // randomized tiles against the matrix-product model
    for (int t = 0; t < 8; t++) begin
      rv = '{2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'(t % 2),
             16, 1'b0, 1'b0, 0, 0};
      run_tile(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Single-tile controller for the 4x4 output-stationary systolic array.
- On a host start command: clears the array, streams VECTOR_LENGTH operand vectors from the A and B operand buffers into the array's row/column feed ports, and waits for tile completion.
- Captures the 16 accumulator results and returns them to the host as a row-major valid/ready stream.
- Sits between the host/DMA control logic and the array; one tile in flight at a time.

## Interface
Parameters
- INPUT_WIDTH, 8, operand element width
- ACC_WIDTH, 16, accumulator/result width
- VECTOR_LENGTH, 4, K: operand vectors fed per tile (≥1)
- ADDR_WIDTH, 8, operand buffer address width
- TIMEOUT, 256, max cycles in WAIT before error abort (≥ VECTOR_LENGTH+16)

Ports
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  host command; accepted only in IDLE with arr_ready_for_feed=1
- a_base  in  ADDR_WIDTH  A buffer base address, latched at start accept
- b_base  in  ADDR_WIDTH  B buffer base address, latched at start accept
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the tile finishes or aborts
- error  out  1  valid with done: 1 = WAIT timeout abort
- a_rd_en  out  1  A buffer read strobe
- a_rd_addr  out  ADDR_WIDTH  A read address
- a_rd_data  in  INPUT_WIDTH*4  A vector k: lane i = A[i][k]; valid one cycle after a_rd_en
- b_rd_en  out  1  B buffer read strobe; always equal to a_rd_en
- b_rd_addr  out  ADDR_WIDTH  B read address
- b_rd_data  in  INPUT_WIDTH*4  B vector k: lane j = B[k][j]; valid one cycle after b_rd_en
- arr_tile_clear  out  1  to array tile_clear
- arr_feed_valid  out  1  to array feed_valid
- arr_row_data  out  INPUT_WIDTH*4  to array row_data_bus
- arr_col_data  out  INPUT_WIDTH*4  to array col_data_bus
- arr_ready_for_feed  in  1  from array
- arr_tile_done  in  1  from array; one-cycle pulse
- arr_result_flat  in  ACC_WIDTH*16  from array; element r*4+c at bits [(r*4+c)*ACC_WIDTH +: ACC_WIDTH]
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  ACC_WIDTH  result element
- res_index  out  4  element index r*4+c
- res_last  out  1  high with index 15

## Operation
- States: IDLE, CLEAR, FEED, WAIT, DRAIN.
- IDLE: when start=1 and arr_ready_for_feed=1, latch a_base/b_base, go to CLEAR. Otherwise start is ignored (no queuing).
- CLEAR: arr_tile_clear=1 for exactly one cycle, then go to FEED. start is ignored in every non-IDLE state.
- FEED: k counter 0..K-1.
  - Each cycle: a_rd_en=b_rd_en=1, a_rd_addr=a_base+k, b_rd_addr=b_base+k. Address arithmetic is modulo 2^ADDR_WIDTH (wraps).
  - arr_feed_valid is a_rd_en delayed one cycle. arr_row_data=a_rd_data and arr_col_data=b_rd_data pass through combinationally.
  - Operand buses are zero whenever arr_feed_valid=0.
  - After the last read, go to WAIT. The final feed_valid beat occurs in the first WAIT cycle.
- WAIT: on arr_tile_done=1, register all 16 results from arr_result_flat that same cycle and go to DRAIN.
  - A watchdog counts WAIT cycles. When the count reaches TIMEOUT without tile_done: pulse done with error=1 and go to IDLE without draining.
- DRAIN: present element idx (0..15, row-major) from the capture register.
  - A beat transfers on res_valid && res_ready; idx then advances.
  - res_data/res_index/res_last are held stable while res_valid && !res_ready.
  - After the idx=15 transfer: pulse done (error=0), go to IDLE.
- arr_tile_done outside WAIT is ignored.
- Reset: state IDLE, counters/capture register zero. All outputs 0: busy, done, error, a_rd_en, b_rd_en, addresses, arr_tile_clear, arr_feed_valid, arr_row_data, arr_col_data, res_valid, res_data, res_index, res_last.
- Reset mid-tile (any state) aborts immediately with no done pulse. The array shares rst, so it resets too.

## Timing
- Start accepted at edge 0. Cycle 1: CLEAR. Cycles 2..K+1: reads. Cycles 3..K+2: feed_valid beats.
- With arr_tile_done at cycle T: res_valid first high at T+1. With res_ready held high, 16 beats occur in T+1..T+16, and done pulses at T+17 with busy=0 in that same cycle.
- Back-to-back tiles: the earliest next start accept is the cycle done is high, provided arr_ready_for_feed=1.
- busy rises the cycle after start accept.
- Timeout: done/error pulse in the cycle the watchdog reaches TIMEOUT, i.e. the TIMEOUT-th WAIT cycle.

## Test plan
- Identity: A=I, B elements 1..16 row-major, K=4, array model attached, res_ready=1 → res_data 1..16 in order, res_last on 16, done=1 with error=0; exactly 4 feed_valid beats in consecutive cycles starting 2 cycles after CLEAR.
- Backpressure: all-2 operands, K=4, res_ready=0 for 3 cycles at idx 5 → idx 5 held stable with value 16; all 16 values equal 16; no beat lost or duplicated.
- Start while busy: pulse start in FEED and again in DRAIN → ignored; exactly one CLEAR pulse and one done.
- Address wrap: a_base=254, b_base=253, ADDR_WIDTH=8 → a_rd_addr 254,255,0,1 and b_rd_addr 253,254,255,0.
- Timeout: stub array never asserts tile_done, TIMEOUT=64 → done=1 with error=1 exactly 64 cycles after WAIT entry; res_valid never asserted; next start accepted.
- Reset mid-FEED: rst during k=2 → next cycle all outputs 0, state IDLE, no done; a fresh start then completes correctly.
